// File: rtl/conv_lb_param_if.sv
// Pixel stream, coefficient write port and result stream of the 3x3
// line-buffered convolution block.
interface conv_lb_param_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 8
);
    localparam int OUT_W = DATA_W + COEF_W + 5;

    logic                     i_en;
    logic [DATA_W-1:0]        din;
    logic                     coef_we;
    logic [3:0]               coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic                     o_en;
    logic signed [OUT_W-1:0]  result;
    logic                     done;
    logic                     busy;

    modport master (
        output i_en, din, coef_we, coef_addr, coef_data,
        input  o_en, result, done, busy
    );

    modport slave (
        input  i_en, din, coef_we, coef_addr, coef_data,
        output o_en, result, done, busy
    );
endinterface

// File: rtl/conv_lb_param.sv
// 3x3 valid-mode convolution over a raster pixel stream. Two line buffers
// feed a 3x3 window; a two-stage multiply/sum pipeline gives a fixed
// latency of two edges from the accepted pixel to the registered result.
// Coefficients are double-banked: writes land in a shadow bank that is
// copied to the active bank when the first pixel of a frame is accepted.
module conv_lb_param #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 512,
    parameter int IMG_H  = 512,
    parameter int COEF_W = 8
) (
    input logic            clk,
    input logic            rst,
    conv_lb_param_if.slave bus
);
    localparam int OUT_W = DATA_W + COEF_W + 5;
    localparam int PW    = DATA_W + COEF_W + 1;
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);

    logic                     run_q, run_d;
    logic [CW-1:0]            col_q, col_d;
    logic [RW-1:0]            row_q, row_d;
    logic [DATA_W-1:0]        lb0 [IMG_W];
    logic [DATA_W-1:0]        lb1 [IMG_W];
    logic [DATA_W-1:0]        win_q [9];
    logic [DATA_W-1:0]        win_d [9];
    logic signed [COEF_W-1:0] shadow_q [9];
    logic signed [COEF_W-1:0] shadow_d [9];
    logic signed [COEF_W-1:0] active_q [9];
    logic signed [COEF_W-1:0] active_d [9];
    logic signed [PW-1:0]     prod_q [9];
    logic signed [PW-1:0]     prod_d [9];
    logic                     v1_q, v1_d, v2_q, v2_d;
    logic                     last1_q, last1_d, last2_q, last2_d, last3_q, last3_d;
    logic                     o_en_q, o_en_d, done_q, done_d, busy_q, busy_d;
    logic signed [OUT_W-1:0]  result_q, result_d;
    logic signed [OUT_W-1:0]  sum;
    logic                     accept, col_end, row_end, frame_start;

    // Pixel acceptance and frame position decode.
    always_comb begin
        run_d       = 1'b1;
        accept      = bus.i_en & run_q;
        col_end     = (col_q == CW'(IMG_W - 1));
        row_end     = (row_q == RW'(IMG_H - 1));
        frame_start = accept && (col_q == '0) && (row_q == '0);
    end

    // Counters, window shift, coefficient banks and the result pipeline.
    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        win_d    = win_q;
        shadow_d = shadow_q;
        if (accept) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            for (int r = 0; r < 3; r++) begin
                win_d[r*3]     = win_q[r*3 + 1];
                win_d[r*3 + 1] = win_q[r*3 + 2];
            end
            win_d[2] = lb1[col_q];
            win_d[5] = lb0[col_q];
            win_d[8] = bus.din;
        end
        if (bus.coef_we && (bus.coef_addr <= 4'd8)) begin
            shadow_d[bus.coef_addr] = bus.coef_data;
        end
        // The copy sees shadow_d so a write on the frame's first edge is taken.
        active_d = frame_start ? shadow_d : active_q;

        // Rows 0/1 of a new frame still hold old-frame lines; row>=2 hides them.
        v1_d    = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
        last1_d = accept && col_end && row_end;
        v2_d    = v1_q;
        last2_d = last1_q;
        for (int k = 0; k < 9; k++) begin
            prod_d[k] = PW'($signed({1'b0, win_q[k]})) * PW'(active_q[k]);
        end
        sum = '0;
        for (int k = 0; k < 9; k++) begin
            sum = sum + OUT_W'(prod_q[k]);
        end
        o_en_d   = v2_q;
        last3_d  = last2_q;
        result_d = v2_q ? sum : result_q;
        done_d   = last3_q;
        // Busy covers a partial frame plus the tail still in the pipeline.
        busy_d   = (col_d != '0) || (row_d != '0) || last1_d || last2_d || last3_d;
    end

    // State registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q    <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            last1_q  <= 1'b0;
            last2_q  <= 1'b0;
            last3_q  <= 1'b0;
            o_en_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            result_q <= '0;
            for (int k = 0; k < 9; k++) begin
                win_q[k]    <= '0;
                prod_q[k]   <= '0;
                shadow_q[k] <= COEF_W'(1);
                active_q[k] <= COEF_W'(1);
            end
        end else begin
            run_q    <= run_d;
            col_q    <= col_d;
            row_q    <= row_d;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            last1_q  <= last1_d;
            last2_q  <= last2_d;
            last3_q  <= last3_d;
            o_en_q   <= o_en_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            result_q <= result_d;
            win_q    <= win_d;
            prod_q   <= prod_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    // Line-buffer RAM: lb0 holds the previous line, lb1 the one before it.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col_q] <= lb0[col_q];
            lb0[col_q] <= bus.din;
        end
    end

    assign bus.o_en   = o_en_q;
    assign bus.result = result_q;
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_conv_lb_param.sv
// Bench for conv_lb_param with a 5x4 image. The reference model computes
// each window sum directly from the frame image and the coefficient set
// latched at the frame's first pixel, and predicts the output edge from
// the accept edge.
module tb_conv_lb_param;
    localparam int DW = 16;
    localparam int CWD = 8;
    localparam int IW = 5;
    localparam int IH = 4;
    localparam int NP = IW * IH;

    logic clk = 1'b0;
    logic rst = 1'b0;

    conv_lb_param_if #(.DATA_W(DW), .COEF_W(CWD)) bus ();

    conv_lb_param #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .COEF_W(CWD)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    longint obs_val[$];
    int     obs_cyc[$];
    int     obs_done[$];
    longint exp_val[$];
    int     exp_cyc[$];
    int     exp_done[$];

    int shadow[9];
    int active[9];
    int img[NP];

    always @(negedge clk) begin
        if (bus.o_en) begin
            obs_val.push_back(longint'(bus.result));
            obs_cyc.push_back(cyc);
        end
        if (bus.done) obs_done.push_back(cyc);
    end

    typedef struct {
        int     ramp;
        int     dval;
        int     ctr;
        int     oth;
        int     gap;
        longint first;
        longint last;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(string nm, longint act, longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_en      = 1'b0;
        bus.din       = '0;
        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
    endtask

    function automatic longint window_sum(int r, int c);
        longint s = 0;
        for (int k = 0; k < 9; k++)
            s += longint'(img[(r - 2 + k / 3) * IW + c - 2 + k % 3]) * longint'(active[k]);
        return s;
    endfunction

    task automatic write_coef(int addr, int val);
        bus.coef_we   = 1'b1;
        bus.coef_addr = 4'(addr);
        bus.coef_data = CWD'(val);
        if (addr <= 8) shadow[addr] = val;
        tick();
        bus.coef_we = 1'b0;
    endtask

    task automatic send_frame(int lead, int max_gap, int n_pix, int wr_idx, int wr_addr, int wr_val);
        int g;
        int r;
        int c;
        int e;
        repeat (lead) tick();
        for (int i = 0; i < n_pix; i++) begin
            if (i > 0 && max_gap > 0) begin
                bus.i_en = 1'b0;
                g = int'($urandom_range(0, max_gap));
                repeat (g) tick();
            end
            bus.i_en = 1'b1;
            bus.din  = DW'(img[i]);
            if (i == wr_idx) begin
                bus.coef_we   = 1'b1;
                bus.coef_addr = 4'(wr_addr);
                bus.coef_data = CWD'(wr_val);
                if (wr_addr <= 8) shadow[wr_addr] = wr_val;
            end
            if (i == 0) active = shadow;
            r = i / IW;
            c = i % IW;
            e = cyc + 1;
            if (r >= 2 && c >= 2) begin
                exp_val.push_back(window_sum(r, c));
                exp_cyc.push_back(e + 2);
            end
            if (i == NP - 1) exp_done.push_back(e + 3);
            tick();
            bus.coef_we = 1'b0;
        end
        bus.i_en = 1'b0;
    endtask

    task automatic check_frames(string nm, int wait_cyc);
        int n;
        longint last_exp;
        repeat (wait_cyc) tick();
        chk($sformatf("%s n_out", nm), obs_val.size(), exp_val.size());
        n = (obs_val.size() < exp_val.size()) ? obs_val.size() : exp_val.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s result[%0d]", nm, i), obs_val[i], exp_val[i]);
            chk($sformatf("%s o_en_cycle[%0d]", nm, i), obs_cyc[i], exp_cyc[i]);
        end
        chk($sformatf("%s n_done", nm), obs_done.size(), exp_done.size());
        n = (obs_done.size() < exp_done.size()) ? obs_done.size() : exp_done.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s done_cycle[%0d]", nm, i), obs_done[i], exp_done[i]);
        if (exp_val.size() > 0) begin
            last_exp = exp_val[exp_val.size() - 1];
            chk($sformatf("%s result_hold", nm), longint'(bus.result), last_exp);
            chk($sformatf("%s busy_idle", nm), bus.busy, 0);
        end
        obs_val.delete();
        obs_cyc.delete();
        obs_done.delete();
        exp_val.delete();
        exp_cyc.delete();
        exp_done.delete();
    endtask

    initial begin
        longint centre_exp[6];
        centre_exp = '{6, 7, 8, 11, 12, 13};

        tbl[0] = '{ramp: 1, dval: 0,     ctr: 1,    oth: 1,    gap: 0, first: 54, last: 117};
        tbl[1] = '{ramp: 1, dval: 0,     ctr: 1,    oth: 0,    gap: 0, first: 6,  last: 13};
        tbl[2] = '{ramp: 0, dval: 100,   ctr: 8,    oth: -1,   gap: 0, first: 0,  last: 0};
        // 65535 * -128 * 9
        tbl[3] = '{ramp: 0, dval: 65535, ctr: -128, oth: -128, gap: 0, first: -75496320, last: -75496320};
        tbl[4] = '{ramp: 1, dval: 0,     ctr: 1,    oth: 1,    gap: 7, first: 54, last: 117};

        idle();
        for (int k = 0; k < 9; k++) shadow[k] = 1;
        active = shadow;
        tick();
        tick();
        chk("reset o_en", bus.o_en, 0);
        chk("reset done", bus.done, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset result", longint'(bus.result), 0);
        rst = 1'b1;
        tick();
        tick();

        for (int t = 0; t < 5; t++) begin
            for (int k = 0; k < 9; k++) write_coef(k, (k == 4) ? tbl[t].ctr : tbl[t].oth);
            for (int i = 0; i < NP; i++) img[i] = (tbl[t].ramp != 0) ? i : tbl[t].dval;
            send_frame(0, tbl[t].gap, NP, -1, 0, 0);
            repeat (12) tick();
            chk($sformatf("vec%0d first", t), (obs_val.size() > 0) ? obs_val[0] : 64'sd999999, tbl[t].first);
            chk($sformatf("vec%0d last", t), (obs_val.size() > 0) ? obs_val[obs_val.size() - 1] : 64'sd999999, tbl[t].last);
            if (t == 1 && obs_val.size() == 6)
                for (int j = 0; j < 6; j++) chk($sformatf("centre[%0d]", j), obs_val[j], centre_exp[j]);
            check_frames($sformatf("vec%0d", t), 0);
        end

        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 9; k++) write_coef(k, int'($urandom_range(0, 255)) - 128);
            write_coef(9 + int'($urandom_range(0, 6)), int'($urandom_range(0, 255)) - 128);
            for (int i = 0; i < NP; i++) img[i] = int'($urandom_range(0, 65535));
            send_frame(0, 3, NP, -1, 0, 0);
            check_frames($sformatf("rand%0d", f), 12);
        end

        for (int k = 0; k < 9; k++) write_coef(k, 1);
        for (int i = 0; i < NP; i++) img[i] = i;
        send_frame(0, 0, NP, 10, 4, 2);
        send_frame(3, 0, NP, -1, 0, 0);
        send_frame(3, 0, NP, 0, 4, 1);
        repeat (12) tick();
        chk("midwrite cur first", (obs_val.size() > 0) ? obs_val[0] : 64'sd999999, 54);
        chk("midwrite next first", (obs_val.size() > 6) ? obs_val[6] : 64'sd999999, 60);
        chk("edge0 write first", (obs_val.size() > 12) ? obs_val[12] : 64'sd999999, 54);
        check_frames("chain", 0);

        send_frame(0, 0, 8, 3, 4, 5);
        chk("partial busy", bus.busy, 1);
        rst = 1'b0;
        #1;
        chk("async rst o_en", bus.o_en, 0);
        chk("async rst done", bus.done, 0);
        chk("async rst busy", bus.busy, 0);
        chk("async rst result", longint'(bus.result), 0);
        tick();
        tick();
        for (int k = 0; k < 9; k++) shadow[k] = 1;
        rst = 1'b1;
        bus.i_en = 1'b1;
        bus.din  = DW'(500);
        tick();
        send_frame(0, 0, NP, -1, 0, 0);
        repeat (12) tick();
        chk("post rst first", (obs_val.size() > 0) ? obs_val[0] : 64'sd999999, 54);
        check_frames("post_rst", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
